// File: rtl/dac_serial_rx.sv
// Serial DAC front end: assembles MSB-first frames from en/sdi bursts and
// moves the 12-bit code into the DAC output register on a good soc.
// Malformed frames (short, overrun, bad header) raise a sticky frame_err
// that the next good frame clears.
module dac_serial_rx #(
  parameter int FRAME_BITS = 16,
  parameter int DATA_BITS  = 12,
  parameter int BURST_BITS = 8,
  parameter int CHECK_HDR  = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 en,
  input  logic                                 sdi,
  input  logic                                 soc,
  output logic [DATA_BITS-1:0]                 dac_code,
  output logic                                 dac_update,
  output logic                                 burst_done,
  output logic                                 frame_err,
  output logic [$clog2(FRAME_BITS+1)-1:0]      bit_cnt
);

  localparam int CNT_W    = $clog2(FRAME_BITS + 1);
  localparam int HDR_BITS = FRAME_BITS - DATA_BITS;

  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_BITS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,    // no bits of a frame captured yet
    S_SHIFT,   // capturing, gaps between bursts allowed
    S_FULL,    // all frame bits in, waiting for soc
    S_UPDATE,  // one cycle: commit code to the DAC register
    S_ERR      // one cycle: flag the error and drop the frame
  } state_e;

  state_e                  state_q,      state_d;
  logic [FRAME_BITS-1:0]   shift_q,      shift_d;
  logic [CNT_W-1:0]        bit_cnt_q,    bit_cnt_d;
  logic [DATA_BITS-1:0]    dac_code_q,   dac_code_d;
  logic                    frame_err_q,  frame_err_d;
  logic                    burst_done_q, burst_done_d;
  logic                    upd_seen_q,   upd_seen_d;
  logic                    dac_update_q, dac_update_d;

  // Header passes when checking is disabled or all header bits are zero.
  function automatic logic hdr_ok(input logic [HDR_BITS-1:0] hdr);
    if (CHECK_HDR == 0) return 1'b1;
    return (hdr == '0);
  endfunction

  // A bit is only taken while a frame is being assembled and not yet full;
  // en in FULL, UPDATE or ERR never reaches the shift register.
  logic                  shift_accept;
  logic [FRAME_BITS-1:0] shift_next;
  logic [CNT_W-1:0]      cnt_next;

  // Candidate shift/count values if this cycle captures a bit.
  always_comb begin
    shift_accept = en && (bit_cnt_q < FRAME_CNT) &&
                   ((state_q == S_IDLE) || (state_q == S_SHIFT));
    shift_next   = {shift_q[FRAME_BITS-2:0], sdi};
    cnt_next     = bit_cnt_q + CNT_ONE;
  end

  // Next-state and datapath decode for the frame FSM.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    dac_code_d   = dac_code_q;
    frame_err_d  = frame_err_q;
    burst_done_d = 1'b0;
    upd_seen_d   = (state_q == S_UPDATE);
    dac_update_d = upd_seen_q;

    if (shift_accept) begin
      shift_d      = shift_next;
      bit_cnt_d    = cnt_next;
      burst_done_d = ((cnt_next % BURST_CNT) == '0);
    end

    case (state_q)
      S_IDLE: begin
        // soc with nothing captured is the controller's idle tick: ignore it.
        if (en) state_d = S_SHIFT;
      end

      S_SHIFT: begin
        if (soc) begin
          // A bit arriving alongside soc is taken first, so soc on the
          // last bit still judges a complete frame.
          if (shift_accept && (cnt_next == FRAME_CNT) &&
              hdr_ok(shift_next[FRAME_BITS-1:DATA_BITS]))
            state_d = S_UPDATE;
          else
            state_d = S_ERR;
        end else if (shift_accept && (cnt_next == FRAME_CNT)) begin
          state_d = S_FULL;
        end
      end

      S_FULL: begin
        // Overrun beats soc when both arrive together.
        if (en)
          state_d = S_ERR;
        else if (soc)
          state_d = hdr_ok(shift_q[FRAME_BITS-1:DATA_BITS]) ? S_UPDATE : S_ERR;
      end

      S_UPDATE: begin
        dac_code_d  = shift_q[DATA_BITS-1:0];
        frame_err_d = 1'b0;
        bit_cnt_d   = '0;
        state_d     = S_IDLE;
      end

      S_ERR: begin
        frame_err_d = 1'b1;
        bit_cnt_d   = '0;
        shift_d     = '0;
        state_d     = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      dac_code_q   <= '0;
      frame_err_q  <= 1'b0;
      burst_done_q <= 1'b0;
      upd_seen_q   <= 1'b0;
      dac_update_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      dac_code_q   <= dac_code_d;
      frame_err_q  <= frame_err_d;
      burst_done_q <= burst_done_d;
      upd_seen_q   <= upd_seen_d;
      dac_update_q <= dac_update_d;
    end
  end

  assign dac_code   = dac_code_q;
  assign dac_update = dac_update_q;
  assign burst_done = burst_done_q;
  assign frame_err  = frame_err_q;
  assign bit_cnt    = bit_cnt_q;

endmodule

// File: tb/tb_dac_serial_rx.sv
// Directed bench for dac_serial_rx: good frames, short frame, overrun,
// header check (both CHECK_HDR settings), soc on the last bit, mid-frame reset.
module tb_dac_serial_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        sdi = 1'b0;
  logic        soc = 1'b0;

  logic [11:0] dac_code,   h0_dac_code;
  logic        dac_update, h0_dac_update;
  logic        burst_done, h0_burst_done;
  logic        frame_err,  h0_frame_err;
  logic [4:0]  bit_cnt,    h0_bit_cnt;

  int checks = 0;
  int passed = 0;
  int burst_seen = 0;

  always #5 clk = ~clk;

  dac_serial_rx #(.CHECK_HDR(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sdi(sdi), .soc(soc),
    .dac_code(dac_code), .dac_update(dac_update), .burst_done(burst_done),
    .frame_err(frame_err), .bit_cnt(bit_cnt)
  );

  dac_serial_rx #(.CHECK_HDR(0)) dut_nohdr (
    .clk(clk), .rst_n(rst_n), .en(en), .sdi(sdi), .soc(soc),
    .dac_code(h0_dac_code), .dac_update(h0_dac_update), .burst_done(h0_burst_done),
    .frame_err(h0_frame_err), .bit_cnt(h0_bit_cnt)
  );

  // Count burst_done pulses of the header-checking instance.
  always @(negedge clk) if (burst_done === 1'b1) burst_seen++;

  // Shift n bits MSB first, one per cycle, then drop en (returns at a negedge).
  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk); en = 1'b1; sdi = v[i];
    end
    @(negedge clk); en = 1'b0; sdi = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // One-cycle soc; returns at the negedge after the sampling edge.
  task automatic pulse_soc();
    @(negedge clk); soc = 1'b1;
    @(negedge clk); soc = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] f);
    send_bits({16'h0, f[15:8]}, 8);
    send_bits({24'h0, f[7:0]}, 8);
  endtask

  task automatic test_reset();
    idle(2);
    checks++; if (dac_code !== 12'h000) $display("FAIL reset_code got %h exp 000", dac_code); else passed++;
    checks++; if (bit_cnt !== 5'd0) $display("FAIL reset_cnt got %0d exp 0", bit_cnt); else passed++;
    checks++; if ({dac_update, burst_done, frame_err} !== 3'b000)
      $display("FAIL reset_flags got %b exp 000", {dac_update, burst_done, frame_err}); else passed++;
    rst_n = 1'b1;
    // soc in IDLE must be ignored.
    pulse_soc(); idle(3);
    checks++; if ({frame_err, dac_code} !== 13'h0000)
      $display("FAIL idle_soc got err=%b code=%h exp err=0 code=000", frame_err, dac_code); else passed++;
  endtask

  task automatic test_basic_frame();
    burst_seen = 0;
    send_bits({24'h0, 8'h0A}, 8);
    checks++; if ({burst_done, bit_cnt} !== {1'b1, 5'd8})
      $display("FAIL burst1 got done=%b cnt=%0d exp done=1 cnt=8", burst_done, bit_cnt); else passed++;
    idle(2);
    send_bits({24'h0, 8'hBC}, 8);
    checks++; if (bit_cnt !== 5'd16) $display("FAIL full_cnt got %0d exp 16", bit_cnt); else passed++;
    pulse_soc();
    checks++; if (dac_update !== 1'b0) $display("FAIL upd_early1 got %b exp 0", dac_update); else passed++;
    @(negedge clk);
    checks++; if (dac_code !== 12'hABC) $display("FAIL basic_code got %h exp abc", dac_code); else passed++;
    checks++; if (dac_update !== 1'b0) $display("FAIL upd_early2 got %b exp 0", dac_update); else passed++;
    @(negedge clk);
    checks++; if (dac_update !== 1'b1) $display("FAIL upd_pulse got %b exp 1", dac_update); else passed++;
    @(negedge clk);
    checks++; if (dac_update !== 1'b0) $display("FAIL upd_width got %b exp 0", dac_update); else passed++;
    checks++; if ({frame_err, bit_cnt} !== {1'b0, 5'd0})
      $display("FAIL basic_state got err=%b cnt=%0d exp 0/0", frame_err, bit_cnt); else passed++;
    checks++; if (burst_seen !== 2) $display("FAIL burst_count got %0d exp 2", burst_seen); else passed++;
  endtask

  task automatic test_short_frame();
    send_bits({24'h0, 8'h12}, 8);
    pulse_soc();
    @(negedge clk);
    checks++; if (frame_err !== 1'b1) $display("FAIL short_err got %b exp 1", frame_err); else passed++;
    checks++; if (bit_cnt !== 5'd0) $display("FAIL short_cnt got %0d exp 0", bit_cnt); else passed++;
    idle(2);
    checks++; if ({dac_update, dac_code} !== {1'b0, 12'hABC})
      $display("FAIL short_code got upd=%b code=%h exp 0/abc", dac_update, dac_code); else passed++;
  endtask

  task automatic test_recover();
    send_frame(16'h0FFF);
    pulse_soc(); idle(2);
    checks++; if (dac_code !== 12'hFFF) $display("FAIL recover_code got %h exp fff", dac_code); else passed++;
    checks++; if (frame_err !== 1'b0) $display("FAIL recover_err got %b exp 0", frame_err); else passed++;
  endtask

  task automatic test_overrun();
    send_bits({15'h0, 16'h0001, 1'b1}, 17);
    checks++; if (bit_cnt !== 5'd16) $display("FAIL sat_cnt got %0d exp 16", bit_cnt); else passed++;
    pulse_soc(); idle(2);
    checks++; if ({frame_err, bit_cnt} !== {1'b1, 5'd0})
      $display("FAIL ovr_state got err=%b cnt=%0d exp 1/0", frame_err, bit_cnt); else passed++;
    checks++; if (dac_code !== 12'hFFF) $display("FAIL ovr_code got %h exp fff", dac_code); else passed++;
    send_frame(16'h0001);
    pulse_soc(); idle(2);
    checks++; if ({frame_err, dac_code} !== {1'b0, 12'h001})
      $display("FAIL ovr_next got err=%b code=%h exp 0/001", frame_err, dac_code); else passed++;
  endtask

  task automatic test_header();
    send_frame(16'h8123);
    pulse_soc(); idle(2);
    checks++; if ({frame_err, dac_code} !== {1'b1, 12'h001})
      $display("FAIL hdr_chk got err=%b code=%h exp 1/001", frame_err, dac_code); else passed++;
    checks++; if ({h0_frame_err, h0_dac_code} !== {1'b0, 12'h123})
      $display("FAIL hdr_nochk got err=%b code=%h exp 0/123", h0_frame_err, h0_dac_code); else passed++;
  endtask

  task automatic test_reset_midframe();
    send_bits({21'h0, 11'h2AA}, 11);
    rst_n = 1'b0;
    #1;
    checks++; if ({dac_code, bit_cnt} !== 17'h0)
      $display("FAIL rst_mid_data got code=%h cnt=%0d exp 000/0", dac_code, bit_cnt); else passed++;
    checks++; if ({dac_update, burst_done, frame_err, h0_dac_code} !== 15'h0)
      $display("FAIL rst_mid_flags got %b/%b/%b h0=%h exp all 0", dac_update, burst_done, frame_err, h0_dac_code); else passed++;
    @(negedge clk); rst_n = 1'b1;
    // Second burst ends with soc on the 16th bit: bit first, then soc.
    send_bits({24'h0, 8'h05}, 8);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk); en = 1'b1; sdi = 8'h55 >> i;
      soc = (i == 0);
    end
    @(negedge clk); en = 1'b0; soc = 1'b0; sdi = 1'b0;
    idle(2);
    checks++; if ({frame_err, dac_code} !== {1'b0, 12'h555})
      $display("FAIL soc_last got err=%b code=%h exp 0/555", frame_err, dac_code); else passed++;
    checks++; if (h0_dac_code !== 12'h555) $display("FAIL soc_last_h0 got %h exp 555", h0_dac_code); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_short_frame();
    test_recover();
    test_overrun();
    test_header();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/dac_serial_rx.md
Name: dac_serial_rx

Overview:
- Receiving end of the serial DAC link: models the serial-input 12-bit DAC front end as synthesizable RTL.
- Driven by the DAC transmission controller through en (shift enable), sdi (serial data) and soc (start of conversion).
- Assembles each 16-bit frame, made of two 8-bit bursts, MSB first, into an input shift register.
- On soc, transfers the 12-bit code to the DAC output register and flags frame errors.
- Used as the on-chip loopback checker and as the DAC stand-in for the sine-wave datapath.

Parameters:
- FRAME_BITS, 16, total bits per frame (burst bits × bursts).
- DATA_BITS, 12, DAC code width; code occupies frame bits [DATA_BITS-1:0].
- BURST_BITS, 8, bits per en burst.
- CHECK_HDR, 1, 1 = frame bits [15:12] must equal 4'b0000, else frame error.

Ports:
- clk  in  1  system clock; all sampling on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  shift enable; one bit of sdi is captured per clk cycle with en=1.
- sdi  in  1  serial data, MSB first.
- soc  in  1  start-of-conversion strobe, single-cycle.
- dac_code  out  12  DAC output register, updated only by a good frame.
- dac_update  out  1  one-cycle pulse, the cycle after dac_code changes.
- burst_done  out  1  one-cycle pulse when a BURST_BITS-bit burst completes.
- frame_err  out  1  sticky error flag; cleared by the next good frame.
- bit_cnt  out  5  bits captured in the current frame, 0..16.

Behaviour:
- Reset, async on rst_n=0: shift register 0, bit_cnt 0, dac_code 0, dac_update 0, burst_done 0, frame_err 0, state IDLE. Reset mid-frame discards the partial frame.
- Shift: on each clk with en=1 and bit_cnt<16, shift_reg <= {shift_reg[14:0], sdi} and bit_cnt increments.
  - burst_done pulses the cycle after bit_cnt reaches 8 or 16.
- FSM states:
  - IDLE: bit_cnt=0. en=1 → SHIFT.
  - SHIFT: capturing; gaps with en=0 between bursts are allowed and hold state.
    - bit_cnt reaching 16 → FULL.
    - soc while bit_cnt<16 → ERR.
  - FULL: waiting for soc.
    - en=1 while in FULL (17th bit): bit ignored, shift_reg unchanged, go to ERR.
    - soc with header ok → UPDATE.
    - soc with header bad (CHECK_HDR=1) → ERR.
  - UPDATE, one cycle: dac_code <= shift_reg[11:0], frame_err <= 0, bit_cnt <= 0, then IDLE.
    - dac_update asserts the following cycle, i.e. 2 clocks after the soc edge.
  - ERR, one cycle: frame_err <= 1, bit_cnt <= 0, shift_reg <= 0, dac_code unchanged, then IDLE.
- Simultaneous events:
  - soc and en in the same cycle in SHIFT with bit_cnt=15: the 16th bit is captured first, then soc is evaluated against the full frame → UPDATE.
  - soc and en together in FULL → ERR (overrun takes priority).
- soc in IDLE (bit_cnt=0): ignored; no error, no update. This covers the controller's ZERO/tick idle phase.
- en in UPDATE or ERR: the bit is dropped; the next frame starts from IDLE on the next en.
- bit_cnt saturates at 16 and never wraps.

Test Plan:
- Reset, then two 8-bit bursts 0x0A, 0xBC with a 3-cycle gap, then soc → dac_code=0xABC, dac_update pulses 2 clocks after soc, frame_err=0, burst_done pulses twice.
- One burst only (8 bits), then soc → frame_err=1, dac_code stays 0xABC, bit_cnt returns to 0.
- Good frame 0x0FFF after an error → dac_code=0xFFF, frame_err clears to 0.
- 17 en cycles, then soc → frame_err=1, dac_code unchanged, extra bit ignored; the next good frame 0x0001 gives dac_code=0x001.
- Header 0x8123 with CHECK_HDR=1 → frame_err=1, dac_code unchanged; same frame with CHECK_HDR=0 → dac_code=0x123.
- rst_n pulsed low after 11 bits → all outputs 0 immediately; the subsequent full frame 0x0555 with soc → dac_code=0x555.
